// File: rtl/slider_gen.sv
// ----------------------------------------------------------------------------
// slider_gen : sliding-piece move generator with memory-mapped control.
//
// Loads a 64-square board (one signed byte per 32-bit word) from memory, then
// walks every enabled ray from the piece at (x,y). For each legal target it
// writes a complete 64-word board to memory: the origin is emptied and the
// piece is placed on the target. The number of boards written is the move count.
//
// Parameters
//   DIR_MASK   enabled directions, bit d = N,NE,E,SE,S,SW,W,NW (d = 0..7)
//   MAX_STEPS  maximum squares per ray (1..7)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   slave_*                  control/status registers:
//                              0 W start / R move count, 1 src, 2 dest,
//                              3 x, 4 y, 5 runtime direction mask [7:0]
//   master_*                 memory master, one transfer at a time
//
// Optional feature macro: SLIDER_CAPTURE_FILTER_EN
//   register 5 bit 8 = captures_only; empty-square moves produce no board.
// ----------------------------------------------------------------------------
module slider_gen #(
    parameter logic [7:0]  DIR_MASK  = 8'hAA,
    parameter int unsigned MAX_STEPS = 7
) (
    input  logic        clk,
    input  logic        rst,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    typedef enum logic [3:0] {
        IDLE, LOAD, LOAD_WAIT, DIR_SEL, STEP, CHECK, EDIT, WRITE, DONE
    } state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_src, r_dest, r_wdata;
    logic [2:0]        r_x, r_y, r_dir, w_sel;
    logic [7:0]        r_mask, r_tried, r_count, w_avail;
    logic [5:0]        r_idx;
    logic [7:0]        r_board [64];
    logic signed [4:0] r_rx, r_ry, w_dx, w_dy;
    logic [3:0]        r_step;
    logic              r_capture;
    logic [7:0]        w_piece, w_target, w_edit_byte;
    logic              w_off, w_friendly, w_ray_end, w_skip, w_last;
`ifdef SLIDER_CAPTURE_FILTER_EN
    logic              r_cap_only;
    logic              w_unused;
    assign w_unused = ^{slave_writedata[31:9], master_readdata[31:8]};
`else
    logic              w_unused;
    assign w_unused = ^{slave_writedata[31:8], master_readdata[31:8]};
`endif

    assign w_piece  = r_board[{r_y, r_x}];
    assign w_target = r_board[{r_ry[2:0], r_rx[2:0]}];
    assign w_avail  = DIR_MASK & r_mask & ~r_tried;
    assign w_last   = (r_idx == 6'd63);

    // Ray coordinates live in signed 5-bit space, so stepping off the edge
    // lands on -1 or 8 instead of wrapping onto the opposite file/rank.
    assign w_off      = (r_rx < 0) || (r_rx > 5'sd7) || (r_ry < 0) || (r_ry > 5'sd7);
    assign w_friendly = (w_target != 8'd0) && (w_target[7] == w_piece[7]);
    assign w_ray_end  = w_off || (r_step > 4'(MAX_STEPS)) || w_friendly;
`ifdef SLIDER_CAPTURE_FILTER_EN
    assign w_skip = r_cap_only && (w_target == 8'd0);
`else
    assign w_skip = 1'b0;
`endif

    // Word being emitted for the current output board.
    assign w_edit_byte = (r_idx == {r_y, r_x})                 ? 8'd0    :
                         (r_idx == {r_ry[2:0], r_rx[2:0]})     ? w_piece :
                                                                 r_board[r_idx];

    // Lowest enabled direction not yet tried.
    always_comb begin
        w_sel = 3'd0;
        for (int d = 7; d >= 0; d--) begin
            if (w_avail[d]) w_sel = 3'(d);
        end
    end

    always_comb begin
        w_dx = 5'sd0;
        w_dy = 5'sd0;
        case (r_dir)
            3'd0: begin w_dx =  5'sd0; w_dy =  5'sd1; end
            3'd1: begin w_dx =  5'sd1; w_dy =  5'sd1; end
            3'd2: begin w_dx =  5'sd1; w_dy =  5'sd0; end
            3'd3: begin w_dx =  5'sd1; w_dy = -5'sd1; end
            3'd4: begin w_dx =  5'sd0; w_dy = -5'sd1; end
            3'd5: begin w_dx = -5'sd1; w_dy = -5'sd1; end
            3'd6: begin w_dx = -5'sd1; w_dy =  5'sd0; end
            default: begin w_dx = -5'sd1; w_dy = 5'sd1; end
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a value held (latch).
    always_comb begin
        w_next            = r_state;
        slave_waitrequest = 1'b1;
        master_read       = 1'b0;
        master_write      = 1'b0;
        master_address    = r_src + {24'd0, r_idx, 2'b00};
        case (r_state)
            IDLE: begin
                slave_waitrequest = 1'b0;
                if (slave_write && slave_address == 4'd0) w_next = LOAD;
            end
            LOAD: begin
                master_read = 1'b1;
                if (!master_waitrequest) w_next = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                if (master_readdatavalid) w_next = w_last ? DIR_SEL : LOAD;
            end
            DIR_SEL: begin
                w_next = (w_piece == 8'd0 || w_avail == 8'd0) ? DONE : STEP;
            end
            STEP:  w_next = CHECK;
            CHECK: begin
                if (w_ray_end)   w_next = DIR_SEL;
                else if (w_skip) w_next = STEP;
                else             w_next = EDIT;
            end
            EDIT:  w_next = WRITE;
            WRITE: begin
                master_write   = 1'b1;
                master_address = r_dest + {16'd0, r_count, r_idx, 2'b00};
                if (!master_waitrequest) begin
                    if (!w_last)        w_next = EDIT;
                    else if (r_capture) w_next = DIR_SEL;
                    else                w_next = STEP;
                end
            end
            DONE: begin
                slave_waitrequest = 1'b0;
                if (slave_read) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Reset overrides the state-derived handshake immediately.
        if (rst) begin
            slave_waitrequest = 1'b1;
            master_read       = 1'b0;
            master_write      = 1'b0;
        end
    end

    assign master_writedata = r_wdata;
    assign slave_readdata   = {24'd0, r_count};

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src     <= 32'd0;
            r_dest    <= 32'd0;
            r_x       <= 3'd0;
            r_y       <= 3'd0;
            r_mask    <= 8'hFF;
            r_count   <= 8'd0;
            r_idx     <= 6'd0;
            r_tried   <= 8'd0;
            r_dir     <= 3'd0;
            r_rx      <= 5'sd0;
            r_ry      <= 5'sd0;
            r_step    <= 4'd0;
            r_capture <= 1'b0;
            r_wdata   <= 32'd0;
`ifdef SLIDER_CAPTURE_FILTER_EN
            r_cap_only <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (slave_write) begin
                    case (slave_address)
                        4'd0: begin
                            r_count <= 8'd0;
                            r_idx   <= 6'd0;
                            r_tried <= 8'd0;
                        end
                        4'd1: r_src  <= slave_writedata;
                        4'd2: r_dest <= slave_writedata;
                        4'd3: r_x    <= slave_writedata[2:0];
                        4'd4: r_y    <= slave_writedata[2:0];
                        4'd5: begin
                            r_mask <= slave_writedata[7:0];
`ifdef SLIDER_CAPTURE_FILTER_EN
                            r_cap_only <= slave_writedata[8];
`endif
                        end
                        default: ;
                    endcase
                end
                LOAD_WAIT: if (master_readdatavalid) r_idx <= r_idx + 6'd1;
                DIR_SEL: if (w_avail != 8'd0) begin
                    r_tried[w_sel] <= 1'b1;
                    r_dir          <= w_sel;
                    r_rx           <= {2'b00, r_x};
                    r_ry           <= {2'b00, r_y};
                    r_step         <= 4'd0;
                end
                STEP: begin
                    r_rx   <= r_rx + w_dx;
                    r_ry   <= r_ry + w_dy;
                    r_step <= r_step + 4'd1;
                end
                CHECK: if (!w_ray_end && !w_skip) begin
                    // A capture ends the ray after its board is written.
                    r_capture <= (w_target != 8'd0);
                    r_idx     <= 6'd0;
                end
                EDIT: r_wdata <= {{24{w_edit_byte[7]}}, w_edit_byte};
                WRITE: if (!master_waitrequest) begin
                    r_idx <= r_idx + 6'd1;
                    if (w_last) r_count <= r_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: board storage has no reset; it is always fully reloaded before use,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (r_state == LOAD_WAIT && master_readdatavalid)
            r_board[r_idx] <= master_readdata[7:0];
    end

endmodule

// File: tb/tb_slider_gen.sv
// ----------------------------------------------------------------------------
// tb_slider_gen : self-checking bench for slider_gen.
// Two instances: a default bishop (AA, 7 steps) and a king-like queen
// (FF, 1 step). A memory responder serves reads/writes with optional random
// waitrequest stalls; a ray-walking reference model predicts every board.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_slider_gen;

    localparam logic [31:0] SRC  = 32'h0000_1000;
    localparam logic [31:0] DEST = 32'h0001_0000;
    localparam int          DWORDS = 27 * 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s_addr;
    logic        s_read, s_write;
    logic [31:0] s_wdata;
    logic        g_sel;     // 0 = bishop instance, 1 = king instance
    logic        g_stall;
    logic        m_wait, m_rdv;
    logic [31:0] m_rdata;

    logic        b_swait, b_mread, b_mwrite, k_swait, k_mread, k_mwrite;
    logic [31:0] b_srdata, b_maddr, b_mwdata, k_srdata, k_maddr, k_mwdata;
    logic        x_swait, m_read, m_write;
    logic [31:0] x_srdata, m_addr, m_wdata;

    always #5 clk = ~clk;

    slider_gen u_bishop (
        .clk(clk), .rst(rst),
        .slave_waitrequest(b_swait), .slave_address(s_addr),
        .slave_read(s_read && !g_sel), .slave_readdata(b_srdata),
        .slave_write(s_write && !g_sel), .slave_writedata(s_wdata),
        .master_waitrequest(m_wait), .master_address(b_maddr),
        .master_read(b_mread), .master_readdata(m_rdata),
        .master_readdatavalid(m_rdv), .master_write(b_mwrite),
        .master_writedata(b_mwdata)
    );

    slider_gen #(.DIR_MASK(8'hFF), .MAX_STEPS(1)) u_king (
        .clk(clk), .rst(rst),
        .slave_waitrequest(k_swait), .slave_address(s_addr),
        .slave_read(s_read && g_sel), .slave_readdata(k_srdata),
        .slave_write(s_write && g_sel), .slave_writedata(s_wdata),
        .master_waitrequest(m_wait), .master_address(k_maddr),
        .master_read(k_mread), .master_readdata(m_rdata),
        .master_readdatavalid(m_rdv), .master_write(k_mwrite),
        .master_writedata(k_mwdata)
    );

    assign x_swait  = g_sel ? k_swait  : b_swait;
    assign x_srdata = g_sel ? k_srdata : b_srdata;
    assign m_read   = g_sel ? k_mread  : b_mread;
    assign m_write  = g_sel ? k_mwrite : b_mwrite;
    assign m_addr   = g_sel ? k_maddr  : b_maddr;
    assign m_wdata  = g_sel ? k_mwdata : b_mwdata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- memory responder ----------------
    logic signed [7:0] tb_board [64];
    logic [31:0]       smem [64];
    logic [31:0]       dmem [DWORDS];
    logic [31:0]       exp_mem [DWORDS];
    int n_reads, n_writes, n_bad, n_overlap, n_hold;

    initial begin
        bit          pend = 0, prev_stall = 0;
        int          dly = 0;
        logic [31:0] rd_word = 0, p_addr = 0, p_data = 0;
        m_wait = 1'b0; m_rdv = 1'b0; m_rdata = 32'd0;
        forever begin
            @(negedge clk);
            m_rdv = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    m_rdv = 1'b1; m_rdata = rd_word; pend = 0;
                end else dly--;
            end
            m_wait = g_stall ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rst) prev_stall = 0;
            if (m_read && m_write) n_overlap++;
            if (m_write && prev_stall && (m_addr !== p_addr || m_wdata !== p_data)) n_hold++;
            prev_stall = m_write && m_wait;
            p_addr = m_addr; p_data = m_wdata;
            if (m_read && !m_wait) begin
                n_reads++;
                if (m_addr < SRC || m_addr >= SRC + 256 || m_addr[1:0] != 2'b00) begin
                    n_bad++; rd_word = 32'd0;
                end else rd_word = smem[(m_addr - SRC) >> 2];
                pend = 1;
                dly  = g_stall ? $urandom_range(0, 3) : 0;
            end
            if (m_write && !m_wait) begin
                n_writes++;
                if (m_addr < DEST || ((m_addr - DEST) >> 2) >= DWORDS || m_addr[1:0] != 2'b00)
                    n_bad++;
                else dmem[(m_addr - DEST) >> 2] = m_wdata;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int dx_of(input int d);
        case (d)
            1, 2, 3: return 1;
            5, 6, 7: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int dy_of(input int d);
        case (d)
            0, 1, 7: return 1;
            3, 4, 5: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int model(input int s, input int x, input int y, input logic [8:0] rmask);
        logic [7:0]        dm;
        int                ms, n, tx, ty;
        logic signed [7:0] p, t, b;
        bit                skip;
        dm = (s != 0 ? 8'hFF : 8'hAA) & rmask[7:0];
        ms = (s != 0) ? 1 : 7;
        p  = tb_board[8 * y + x];
        n  = 0;
        if (p == 0) return 0;
        for (int d = 0; d < 8; d++) begin
            if (!dm[d]) continue;
            for (int st = 1; st <= ms; st++) begin
                tx = x + dx_of(d) * st;
                ty = y + dy_of(d) * st;
                if (tx < 0 || tx > 7 || ty < 0 || ty > 7) break;
                t = tb_board[8 * ty + tx];
                if (t != 0 && ((t < 0) == (p < 0))) break;
                skip = 0;
`ifdef SLIDER_CAPTURE_FILTER_EN
                skip = rmask[8] && (t == 0);
`endif
                if (!skip) begin
                    for (int i = 0; i < 64; i++) begin
                        if (i == 8 * y + x)        b = 8'sd0;
                        else if (i == 8 * ty + tx) b = p;
                        else                       b = tb_board[i];
                        exp_mem[n * 64 + i] = 32'(int'(b));
                    end
                    n++;
                end
                if (t != 0) break;
            end
        end
        return n;
    endfunction

    // ---------------- slave access ----------------
    task automatic slave_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        s_addr = a; s_wdata = d; s_write = 1'b1;
        @(posedge clk); #1;
        s_write = 1'b0;
    endtask

    task automatic slave_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        s_addr = a; s_read = 1'b1;
        #1 d = x_srdata;
        @(posedge clk); #1;
        s_read = 1'b0;
    endtask

    task automatic start_job(input int s, input int x, input int y,
                             input logic [8:0] rmask, input bit stall);
        logic [31:0] r;
        g_sel = 1'(s); g_stall = stall;
        for (int i = 0; i < 64; i++) begin
            r = $urandom();
            smem[i] = {r[31:8], tb_board[i]};
        end
        for (int i = 0; i < DWORDS; i++) dmem[i] = 32'hDEAD_BEEF;
        n_reads = 0; n_writes = 0; n_bad = 0; n_overlap = 0; n_hold = 0;
        slave_wr(4'd1, SRC);
        slave_wr(4'd2, DEST);
        slave_wr(4'd3, 32'(x));
        slave_wr(4'd4, 32'(y));
        slave_wr(4'd5, {23'd0, rmask});
        slave_wr(4'd0, 32'd0);
    endtask

    task automatic run_job(input string tag, input int s, input int x, input int y,
                           input logic [8:0] rmask, input bit stall, output int got);
        int          e;
        logic [31:0] cnt;
        start_job(s, x, y, rmask, stall);
        for (int c = 0; c < 20000 && x_swait; c++) @(negedge clk);
        check({tag, "_done"}, {31'd0, x_swait}, 32'd0);
        slave_rd(4'd0, cnt);
        e   = model(s, x, y, rmask);
        got = int'(cnt);
        check({tag, "_count"}, cnt, 32'(e));
        check({tag, "_reads"}, 32'(n_reads), 32'd64);
        check({tag, "_writes"}, 32'(n_writes), 32'(64 * e));
        check({tag, "_badaddr"}, 32'(n_bad), 32'd0);
        check({tag, "_rw_overlap"}, 32'(n_overlap), 32'd0);
        check({tag, "_stall_hold"}, 32'(n_hold), 32'd0);
        for (int k = 0; k < e * 64; k++) check({tag, "_word"}, dmem[k], exp_mem[k]);
        @(negedge clk);
        check({tag, "_idle"}, {31'd0, x_swait}, 32'd0);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) tb_board[i] = 8'sd0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          got;
        logic [31:0] rd;
        logic [31:0] r;
        int          s, x, y;
        rst = 1'b1; s_addr = 4'd0; s_read = 1'b0; s_write = 1'b0; s_wdata = 32'd0;
        g_sel = 1'b0; g_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_b_swait", {31'd0, b_swait}, 32'd1);
        check("rst_k_swait", {31'd0, k_swait}, 32'd1);
        check("rst_b_mread", {31'd0, b_mread}, 32'd0);
        check("rst_b_mwrite", {31'd0, b_mwrite}, 32'd0);
        check("rst_k_mrw", {30'd0, k_mread, k_mwrite}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_swait", {31'd0, b_swait}, 32'd0);
        slave_rd(4'd0, rd);
        check("rst_count", rd, 32'd0);

        // Lone white bishop at (3,3).
        clear_board(); tb_board[27] = 8'sd3;
        run_job("bishop_lone", 0, 3, 3, 9'h0FF, 1'b0, got);
        check("bishop_lone_13", 32'(got), 32'd13);

        // Black piece at (5,5), white piece at (1,1).
        tb_board[45] = -8'sd1; tb_board[9] = 8'sd5;
        run_job("bishop_block", 0, 3, 3, 9'h0FF, 1'b0, got);
        check("bishop_block_9", 32'(got), 32'd9);

        // King-like queen in the corner.
        clear_board(); tb_board[0] = 8'sd9;
        run_job("king_corner", 1, 0, 0, 9'h0FF, 1'b0, got);
        check("king_corner_3", 32'(got), 32'd3);

        // Empty source square.
        clear_board();
        run_job("empty_sq", 0, 4, 4, 9'h0FF, 1'b0, got);
        check("empty_sq_0", 32'(got), 32'd0);

        // Lone bishop again with random stalls.
        tb_board[27] = 8'sd3;
        run_job("bishop_stall", 0, 3, 3, 9'h0FF, 1'b1, got);
        check("bishop_stall_13", 32'(got), 32'd13);

        // Reset during the second board write.
        start_job(0, 3, 3, 9'h0FF, 1'b0);
        for (int c = 0; c < 5000 && n_writes < 72; c++) @(negedge clk);
        check("midrst_reached", {31'd0, (n_writes >= 72)}, 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_mwrite", {31'd0, b_mwrite}, 32'd0);
        check("midrst_swait", {31'd0, b_swait}, 32'd1);
        @(negedge clk); rst = 1'b0;
        #1 check("midrst_idle", {31'd0, b_swait}, 32'd0);
        clear_board();
        run_job("midrst_fresh", 0, 3, 3, 9'h0FF, 1'b0, got);
        check("midrst_fresh_0", 32'(got), 32'd0);

        // Randomised boards, masks and stalls on both instances.
        for (int k = 0; k < 6; k++) begin
            s = $urandom_range(0, 1);
            x = $urandom_range(0, 7);
            y = $urandom_range(0, 7);
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    r = $urandom_range(1, 127);
                    tb_board[i] = $urandom_range(0, 1) ? -8'(r) : 8'(r);
                end else tb_board[i] = 8'sd0;
            end
            if (tb_board[8 * y + x] == 0) tb_board[8 * y + x] = (k % 2 == 0) ? 8'sd7 : -8'sd7;
            r = $urandom();
            run_job("random", s, x, y, r[8:0] | 9'h001, 1'(k % 2), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/slider_gen.md
SLIDER_GEN -- requirements
Module: slider_gen

Interface
REQ-001 SHALL have parameter DIR_MASK, default 8'hAA, meaning enabled directions: bit d = direction d (0 N, 1 NE, 2 E, 3 SE, 4 S, 5 SW, 6 W, 7 NW); the default gives diagonals, i.e. bishop.
REQ-002 SHALL have parameter MAX_STEPS, default 7, meaning max squares per ray, range 1..7; a value of 1 gives king-like stepping.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have slave ports slave_waitrequest out 1, slave_address in 4, slave_read in 1, slave_readdata out 32, slave_write in 1, slave_writedata in 32.
REQ-006 SHALL have master ports master_waitrequest in 1, master_address out 32, master_read out 1, master_readdata in 32, master_readdatavalid in 1, master_write out 1, master_writedata out 32.
REQ-007 SHALL use this slave register map: 1 = src byte address, 2 = dest byte address, 3 = x (0..7), 4 = y (0..7), 5 = runtime direction mask (bits 7:0, ANDed with DIR_MASK), 0 = write starts the job, read returns the move count.

Function
REQ-008 SHALL use states IDLE, LOAD, LOAD_WAIT, DIR_SEL, STEP, CHECK, EDIT, WRITE, DONE.
REQ-009 SHALL hold slave_waitrequest low in IDLE and DONE and high in all other states.
REQ-010 SHALL, in IDLE, latch registers 1-5 on slave_write; a write to address 0 SHALL clear the move count and go to LOAD.
REQ-011 SHALL, in LOAD, read 64 words at src+4*i (i = 0..63), one outstanding read at a time, holding master_read high until waitrequest is low, then wait in LOAD_WAIT for readdatavalid.
REQ-012 SHALL store the signed byte [7:0] of each word; the piece is board[8y+x]; its colour is the sign (positive white, negative black, zero empty).
REQ-013 SHALL, if the piece square is empty, skip move generation and go to DONE with count 0.
REQ-014 SHALL, in DIR_SEL, choose the lowest enabled untried direction, reset the ray to (x,y) and zero the step counter, and go to DONE when no direction remains.
REQ-015 SHALL, in STEP, add the direction delta in signed 5-bit arithmetic, so off-board results (-1, 8) are detected without wrap-around.
REQ-016 SHALL, in CHECK, end the ray when the square is off-board or friendly, or when the step count exceeds MAX_STEPS; an empty or enemy square SHALL produce a move.
REQ-017 SHALL, when a capture produces a move, mark the ray finished once that board has been written.
REQ-018 SHALL, for each move n (0-based), write 64 words at dest + 4*(64n + i), each with sign-extended data: 0 at the origin, the piece at the target, the source byte elsewhere.
REQ-019 SHALL, in WRITE, hold master_write, address and data stable while master_waitrequest is high; i advances only on an accepted write.
REQ-020 SHALL never assert master_read and master_write in the same cycle.
REQ-021 SHALL increment the move count once per completed board (max 27 for a centre queen) and drive it zero-extended on slave_readdata.
REQ-022 SHALL, in DONE, return to IDLE on slave_read; the count SHALL remain readable until the next start.
REQ-023 SHALL ignore slave writes while busy (waitrequest high).

Reset
REQ-024 SHALL, on rst, go to IDLE next edge, mid-job included, with no completion signalled.
REQ-025 SHALL, on rst, set master_read = 0, master_write = 0, slave_waitrequest = 1 during reset, move count = 0 and latched mask = 8'hFF; board storage SHALL NOT be cleared.

Configuration
REQ-026 SHALL, when SLIDER_CAPTURE_FILTER_EN is defined, implement register 5 bit 8 = captures_only: when set, empty-square moves are skipped (ray continues, no board written, no count).
REQ-027 SHALL, without SLIDER_CAPTURE_FILTER_EN, ignore register 5 bit 8 and keep no filter logic.

Verification
REQ-028 Bishop (DIR_MASK AA, MAX_STEPS 7), lone white bishop at (3,3) on an empty board -> count 13, 13*64 writes, each board has bishop at target and 0 at (3,3).
REQ-029 Same, with a black piece at (5,5) and a white piece at (1,1) -> NE ray gives 2 moves, SW ray gives 1 move; count 9.
REQ-030 Queen (FF), MAX_STEPS 1, white piece at corner (0,0), empty board -> count 3 (N, NE, E).
REQ-031 Empty source square -> count 0, zero master writes, DONE reached.
REQ-032 Random master_waitrequest stalls on reads and writes -> identical dest memory and count to the no-stall run.
REQ-033 rst asserted during WRITE of board 2 -> next cycle master_write = 0, state IDLE, count reads 0 after a fresh start with an empty square.
